// File: rtl/pcie_dma_pkg.sv
// Shared PCIe DMA definitions: FSM state type, DW size and chunk helper.
// The chunk helper is used by both the write and read request generators.
package pcie_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_REQ,
        ST_DONE
    } dma_state_e;

    localparam int unsigned DW_BYTES = 4;

    // Bytes to the next MPS-aligned boundary, capped by the bytes remaining.
    function automatic logic [31:0] dma_chunk(
        input logic [31:0] addr,
        input logic [31:0] rem,
        input logic [31:0] mps
    );
        logic [31:0] room;
        room = mps - (addr & (mps - 32'd1));
        return (rem < room) ? rem : room;
    endfunction

endpackage

// File: rtl/dma_wr_req_gen.sv
// DMA write request generator: splits a transfer into MPS-bounded requests.
// Optional statistics counters are built when DMA_WR_STATS_EN is defined.
module dma_wr_req_gen
    import pcie_dma_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_BYTES = 128
) (
    input  logic        pcie_clk,
    input  logic        pcie_rst,
    input  logic        dma_wr_start,
    input  logic [31:0] dma_wr_addr,
    input  logic [31:0] dma_wr_len,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic [9:0]  req_len_dw,
    output logic        req_last,
    output logic        dma_wr_busy,
`ifdef DMA_WR_STATS_EN
    output logic [31:0] stat_req_cnt,
    output logic [15:0] stat_drop_cnt,
`endif
    output logic        dma_wr_done
);

    localparam logic [31:0] MPS     = 32'(MAX_PAYLOAD_BYTES);
    localparam logic [31:0] DW_MASK = ~32'(DW_BYTES - 1);

    dma_state_e  state_q;
    dma_state_e  state_d;
    logic [31:0] cur_addr;
    logic [31:0] rem;
    logic [31:0] chunk;
    logic [31:0] req_bytes;
    logic [31:0] start_addr;
    logic [31:0] start_len;
    logic        hs;

    assign start_addr = dma_wr_addr & DW_MASK;
    assign start_len  = dma_wr_len & DW_MASK;
    assign chunk      = dma_chunk(cur_addr, rem, MPS);
    assign req_bytes  = {20'd0, req_len_dw, 2'b00};

    assign req_valid   = (state_q == ST_REQ);
    assign hs          = req_valid && req_ready;
    assign dma_wr_busy = (state_q != ST_IDLE);
    assign dma_wr_done = (state_q == ST_DONE);

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dma_wr_start) begin
                    state_d = (start_len != 32'd0) ? ST_CALC : ST_DONE;
                end
            end
            ST_CALC: state_d = ST_REQ;
            ST_REQ: begin
                if (req_ready) begin
                    state_d = req_last ? ST_DONE : ST_CALC;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The request registers double as the chunk store for the handshake update.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            cur_addr   <= '0;
            rem        <= '0;
            req_addr   <= '0;
            req_len_dw <= '0;
            req_last   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dma_wr_start) begin
                        cur_addr <= start_addr;
                        rem      <= start_len;
                    end
                end
                ST_CALC: begin
                    req_addr   <= cur_addr;
                    req_len_dw <= 10'(chunk >> 2);
                    req_last   <= (chunk == rem);
                end
                ST_REQ: begin
                    if (req_ready) begin
                        cur_addr <= cur_addr + req_bytes;
                        rem      <= rem - req_bytes;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DMA_WR_STATS_EN
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            stat_req_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (hs) begin
                stat_req_cnt <= stat_req_cnt + 32'd1;
            end
            if (dma_wr_start && dma_wr_busy && stat_drop_cnt != 16'hFFFF) begin
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dma_wr_req_gen.sv
// Testbench for dma_wr_req_gen: directed and random transfers checked
// against a byte-level split model; stat ports follow DMA_WR_STATS_EN.
module tb_dma_wr_req_gen;

    localparam int MPS = 128;

    typedef struct {
        logic [31:0] a;
        logic [9:0]  n;
        logic        l;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [9:0]  n;
        logic        l;
        int          c;
    } hs_t;

    logic        clk;
    logic        pcie_rst;
    logic        dma_wr_start;
    logic [31:0] dma_wr_addr;
    logic [31:0] dma_wr_len;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [9:0]  req_len_dw;
    logic        req_last;
    logic        dma_wr_busy;
    logic        dma_wr_done;
`ifdef DMA_WR_STATS_EN
    logic [31:0] stat_req_cnt;
    logic [15:0] stat_drop_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rdy_mode = 1;
    int   hold_err = 0;
    int   model_reqs = 0;
    int   model_drops = 0;
    exp_t exp_q[$];
    hs_t  hs_q[$];
    int   done_q[$];

    logic        prev_wait = 1'b0;
    logic [31:0] h_a;
    logic [9:0]  h_n;
    logic        h_l;

    dma_wr_req_gen #(.MAX_PAYLOAD_BYTES(MPS)) dut (
        .pcie_clk     (clk),
        .pcie_rst     (pcie_rst),
        .dma_wr_start (dma_wr_start),
        .dma_wr_addr  (dma_wr_addr),
        .dma_wr_len   (dma_wr_len),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_len_dw   (req_len_dw),
        .req_last     (req_last),
        .dma_wr_busy  (dma_wr_busy),
`ifdef DMA_WR_STATS_EN
        .stat_req_cnt (stat_req_cnt),
        .stat_drop_cnt(stat_drop_cnt),
`endif
        .dma_wr_done  (dma_wr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        req_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: req_ready = 1'b0;
                1: req_ready = 1'b1;
                default: req_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (pcie_rst) begin
            prev_wait <= 1'b0;
        end else begin
            if (prev_wait) begin
                if (!req_valid || req_addr !== h_a ||
                    req_len_dw !== h_n || req_last !== h_l)
                    hold_err <= hold_err + 1;
            end
            if (req_valid && req_ready)
                hs_q.push_back('{req_addr, req_len_dw, req_last, cyc});
            if (dma_wr_done)
                done_q.push_back(cyc);
            prev_wait <= req_valid && !req_ready;
            h_a <= req_addr;
            h_n <= req_len_dw;
            h_l <= req_last;
        end
    end

    // Reference split: walk the byte range, cutting at each MPS multiple.
    function automatic void build_exp(input logic [31:0] addr,
                                      input logic [31:0] len);
        longint a, r, bnd, room, c;
        exp_t e;
        a = {32'd0, addr} & ~64'd3;
        r = {32'd0, len} & ~64'd3;
        exp_q.delete();
        while (r > 0) begin
            bnd  = (a / MPS + 1) * MPS;
            room = bnd - a;
            c    = (r < room) ? r : room;
            e.a  = a[31:0];
            e.n  = 10'(c / 4);
            e.l  = (c == r);
            exp_q.push_back(e);
            a = (a + c) % 64'h1_0000_0000;
            r = r - c;
        end
        model_reqs += exp_q.size();
    endfunction

    task automatic do_start(input logic [31:0] a, input logic [31:0] l,
                            output int t);
        hs_q.delete();
        done_q.delete();
        @(posedge clk); #2;
        dma_wr_start = 1'b1;
        dma_wr_addr  = a;
        dma_wr_len   = l;
        t = cyc;
        @(posedge clk); #2;
        dma_wr_start = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit to);
        int n = 0;
        while (done_q.size() == 0 && n < max) begin
            @(posedge clk); #2;
            n++;
        end
        to = (done_q.size() == 0);
    endtask

    task automatic test_reset();
        pcie_rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", req_valid);
        end
        checks++;
        if (req_addr !== 32'd0) begin
            errors++; $display("FAIL reset_addr: got %h want 0", req_addr);
        end
        checks++;
        if (req_len_dw !== 10'd0 || req_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_len_last: got %0d/%b want 0/0", req_len_dw, req_last);
        end
        checks++;
        if (dma_wr_busy !== 1'b0 || dma_wr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done: got %b/%b want 0/0", dma_wr_busy, dma_wr_done);
        end
`ifdef DMA_WR_STATS_EN
        checks++;
        if (stat_req_cnt !== 32'd0 || stat_drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_req_cnt, stat_drop_cnt);
        end
`endif
        model_reqs = 0;
        model_drops = 0;
        @(posedge clk); #2;
        pcie_rst = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_split();
        int t;
        bit to;
        rdy_mode = 1;
        @(posedge clk); #2;
        build_exp(32'h0000_1000, 32'd256);
        do_start(32'h0000_1000, 32'd256, t);
        checks++;
        if (dma_wr_busy !== 1'b1) begin
            errors++; $display("FAIL split_busy_rise: got %b want 1", dma_wr_busy);
        end
        wait_done(200, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL split_timeout: got no done want done");
        end
        checks++;
        if (hs_q.size() != 2) begin
            errors++; $display("FAIL split_count: got %0d want 2", hs_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (hs_q[i].a !== exp_q[i].a || hs_q[i].n !== exp_q[i].n ||
                    hs_q[i].l !== exp_q[i].l) begin
                    errors++;
                    $display("FAIL split_req%0d: got %h/%0d/%b want %h/%0d/%b", i,
                             hs_q[i].a, hs_q[i].n, hs_q[i].l,
                             exp_q[i].a, exp_q[i].n, exp_q[i].l);
                end
            end
            checks++;
            if (hs_q[0].c != t + 2 || hs_q[1].c != t + 4) begin
                errors++;
                $display("FAIL split_hs_timing: got T+%0d,T+%0d want T+2,T+4",
                         hs_q[0].c - t, hs_q[1].c - t);
            end
            if (!to) begin
                checks++;
                if (done_q[0] != t + 5) begin
                    errors++;
                    $display("FAIL split_done_timing: got T+%0d want T+5", done_q[0] - t);
                end
            end
        end
        checks++;
        if (dma_wr_busy !== 1'b0) begin
            errors++; $display("FAIL split_busy_fall: got %b want 0", dma_wr_busy);
        end
    endtask

    task automatic test_unaligned();
        logic [31:0] va [2];
        logic [31:0] vl [2];
        int t;
        bit to;
        va[0] = 32'h0000_01F0; vl[0] = 32'd64;
        va[1] = 32'hFFFF_FFC3; vl[1] = 32'd259;
        rdy_mode = 1;
        for (int k = 0; k < 2; k++) begin
            build_exp(va[k], vl[k]);
            do_start(va[k], vl[k], t);
            wait_done(300, to);
            checks++;
            if (to || hs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL unaligned%0d_count: got %0d want %0d", k,
                         hs_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (hs_q[i].a !== exp_q[i].a || hs_q[i].n !== exp_q[i].n ||
                        hs_q[i].l !== exp_q[i].l) begin
                        errors++;
                        $display("FAIL unaligned%0d_req%0d: got %h/%0d/%b want %h/%0d/%b",
                                 k, i, hs_q[i].a, hs_q[i].n, hs_q[i].l,
                                 exp_q[i].a, exp_q[i].n, exp_q[i].l);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int t;
        int n;
        bit to;
        rdy_mode = 0;
        hold_err = 0;
        build_exp(32'h0000_1000, 32'd64);
        do_start(32'h0000_1000, 32'd64, t);
        n = 0;
        while (!req_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        repeat (5) begin
            @(posedge clk); #2;
        end
        checks++;
        if (req_valid !== 1'b1 || hs_q.size() != 0) begin
            errors++;
            $display("FAIL bp_stall: got valid=%b hs=%0d want valid=1 hs=0",
                     req_valid, hs_q.size());
        end
        rdy_mode = 1;
        wait_done(50, to);
        checks++;
        if (hold_err != 0) begin
            errors++; $display("FAIL bp_hold: got %0d changes want 0", hold_err);
        end
        checks++;
        if (to || hs_q.size() != 1) begin
            errors++; $display("FAIL bp_count: got %0d want 1", hs_q.size());
        end else begin
            checks++;
            if (hs_q[0].a !== exp_q[0].a || hs_q[0].n !== exp_q[0].n ||
                hs_q[0].l !== exp_q[0].l) begin
                errors++;
                $display("FAIL bp_req: got %h/%0d/%b want %h/%0d/%b",
                         hs_q[0].a, hs_q[0].n, hs_q[0].l,
                         exp_q[0].a, exp_q[0].n, exp_q[0].l);
            end
        end
    endtask

    task automatic test_zero_len();
        int t;
        bit to;
        rdy_mode = 1;
        do_start(32'h0000_2000, 32'h0000_0003, t);
        wait_done(20, to);
        checks++;
        if (to || done_q[0] != t + 1) begin
            errors++;
            $display("FAIL zero_done: got T+%0d want T+1", to ? -1 : done_q[0] - t);
        end
        checks++;
        if (hs_q.size() != 0) begin
            errors++; $display("FAIL zero_reqs: got %0d want 0", hs_q.size());
        end
    endtask

    task automatic test_busy_start();
        int t;
        bit to;
        rdy_mode = 1;
        build_exp(32'h0000_3000, 32'd512);
        do_start(32'h0000_3000, 32'd512, t);
        @(posedge clk); #2;
        dma_wr_start = 1'b1;
        dma_wr_addr  = 32'h0000_9990;
        dma_wr_len   = 32'd8;
        @(posedge clk); #2;
        dma_wr_start = 1'b0;
        model_drops++;
        wait_done(300, to);
        checks++;
        if (to || hs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL busy_count: got %0d want %0d", hs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (hs_q[i].a !== exp_q[i].a || hs_q[i].n !== exp_q[i].n ||
                    hs_q[i].l !== exp_q[i].l) begin
                    errors++;
                    $display("FAIL busy_req%0d: got %h/%0d/%b want %h/%0d/%b", i,
                             hs_q[i].a, hs_q[i].n, hs_q[i].l,
                             exp_q[i].a, exp_q[i].n, exp_q[i].l);
                end
            end
        end
        repeat (4) begin
            @(posedge clk); #2;
        end
        checks++;
        if (done_q.size() != 1) begin
            errors++; $display("FAIL busy_extra_done: got %0d want 1", done_q.size());
        end
`ifdef DMA_WR_STATS_EN
        checks++;
        if (stat_drop_cnt !== 16'(model_drops) || stat_req_cnt !== 32'(model_reqs)) begin
            errors++;
            $display("FAIL busy_stats: got %0d/%0d want %0d/%0d",
                     stat_drop_cnt, stat_req_cnt, model_drops, model_reqs);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int t;
        int n;
        bit to;
        rdy_mode = 0;
        do_start(32'h0000_2000, 32'd384, t);
        n = 0;
        while (!req_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        pcie_rst = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (req_valid !== 1'b0 || req_addr !== 32'd0 || req_len_dw !== 10'd0 ||
            req_last !== 1'b0 || dma_wr_busy !== 1'b0 || dma_wr_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got v=%b a=%h n=%0d l=%b b=%b d=%b want all 0",
                     req_valid, req_addr, req_len_dw, req_last, dma_wr_busy, dma_wr_done);
        end
`ifdef DMA_WR_STATS_EN
        checks++;
        if (stat_req_cnt !== 32'd0 || stat_drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_stats: got %0d/%0d want 0/0", stat_req_cnt, stat_drop_cnt);
        end
`endif
        model_reqs = 0;
        model_drops = 0;
        pcie_rst = 1'b0;
        rdy_mode = 1;
        repeat (6) begin
            @(posedge clk); #2;
        end
        checks++;
        if (done_q.size() != 0 || hs_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_quiet: got done=%0d hs=%0d want 0/0",
                     done_q.size(), hs_q.size());
        end
        build_exp(32'h0000_2000, 32'd384);
        do_start(32'h0000_2000, 32'd384, t);
        wait_done(300, to);
        checks++;
        if (to || hs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midrst_restart: got %0d want %0d", hs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (hs_q[i].a !== exp_q[i].a || hs_q[i].n !== exp_q[i].n ||
                    hs_q[i].l !== exp_q[i].l) begin
                    errors++;
                    $display("FAIL midrst_req%0d: got %h/%0d/%b want %h/%0d/%b", i,
                             hs_q[i].a, hs_q[i].n, hs_q[i].l,
                             exp_q[i].a, exp_q[i].n, exp_q[i].l);
                end
            end
        end
    endtask

    task automatic test_random();
        int t;
        bit to;
        logic [31:0] a;
        logic [31:0] l;
        int bad;
        int want_done;
        rdy_mode = 2;
        for (int k = 0; k < 16; k++) begin
            a = $urandom;
            l = (k % 4 == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(4, 1100));
            build_exp(a, l);
            do_start(a, l, t);
            wait_done(4000, to);
            bad = 0;
            if (to || hs_q.size() != exp_q.size()) begin
                bad = 1;
            end else begin
                foreach (exp_q[i]) begin
                    if (hs_q[i].a !== exp_q[i].a || hs_q[i].n !== exp_q[i].n ||
                        hs_q[i].l !== exp_q[i].l)
                        bad = 1;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand%0d_seq: got %0d reqs want %0d (addr %h len %0d)",
                         k, hs_q.size(), exp_q.size(), a, l);
            end
            if (!to) begin
                want_done = (hs_q.size() > 0) ? hs_q[hs_q.size() - 1].c + 1 : t + 1;
                checks++;
                if (done_q[0] != want_done) begin
                    errors++;
                    $display("FAIL rand%0d_done: got cycle %0d want %0d",
                             k, done_q[0], want_done);
                end
            end
        end
`ifdef DMA_WR_STATS_EN
        checks++;
        if (stat_req_cnt !== 32'(model_reqs)) begin
            errors++;
            $display("FAIL rand_stat_req: got %0d want %0d", stat_req_cnt, model_reqs);
        end
`endif
        rdy_mode = 1;
    endtask

    initial begin
        pcie_rst     = 1'b1;
        dma_wr_start = 1'b0;
        dma_wr_addr  = '0;
        dma_wr_len   = '0;
        test_reset();
        test_split();
        test_unaligned();
        test_backpressure();
        test_zero_len();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_wr_req_gen.md
# dma_wr_req_gen

DMA write request generator sitting directly downstream of the BAR0 register block. It consumes the single-cycle `dma_wr_start` pulse plus `dma_wr_addr`/`dma_wr_len` and splits the transfer into memory-write requests for the TX TLP engine. Each request is no larger than the max payload and never crosses a MAX_PAYLOAD-aligned boundary, and therefore never crosses a 4 KB boundary. The block reports busy, completion and (optionally) statistics.

## Interface
- `MAX_PAYLOAD_BYTES`, 128: max payload per request in bytes; power of two, 128..512.
- `pcie_clk`  in  1  125 MHz clock; the only clock.
- `pcie_rst`  in  1  reset; synchronous, active-high.
- `dma_wr_start`  in  1  one-cycle start pulse.
- `dma_wr_addr`  in  32  host byte address; bits [1:0] ignored (treated as 0).
- `dma_wr_len`  in  32  byte length; bits [1:0] ignored (rounded down to whole DW).
- `req_valid`  out  1  request valid.
- `req_ready`  in  1  TX engine accepts the request.
- `req_addr`  out  32  request byte address, DW aligned.
- `req_len_dw`  out  10  request length in DW, 1..MAX_PAYLOAD_BYTES/4.
- `req_last`  out  1  marks the final request of the transfer.
- `dma_wr_busy`  out  1  high from the cycle after an accepted start until the cycle after done.
- `dma_wr_done`  out  1  one-cycle completion pulse.
- `stat_req_cnt`  out  32  requests issued since reset (DMA_WR_STATS_EN only).
- `stat_drop_cnt`  out  16  starts ignored while busy (DMA_WR_STATS_EN only).

## Operation
- States: IDLE, CALC, REQ, DONE.
- **IDLE**
  - On `dma_wr_start`: latch `cur_addr = {addr[31:2],2'b0}` and `rem = {len[31:2],2'b0}`.
  - Go to CALC if `rem != 0`, otherwise go to DONE.
- **CALC**
  - Compute `room = MPS - cur_addr[log2(MPS)-1:0]` and `chunk = min(rem, room)`.
  - Register `req_addr = cur_addr`, `req_len_dw = chunk>>2`, `req_last = (chunk == rem)`.
  - Go to REQ.
- **REQ**
  - `req_valid = 1`. All `req_*` outputs are held stable until `req_ready`.
  - On the handshake: `cur_addr += chunk`, `rem -= chunk`.
  - Go to DONE if `req_last`, otherwise go to CALC.
- **DONE**: `dma_wr_done = 1` for one cycle, then go to IDLE.
- `dma_wr_start` outside IDLE is ignored; the current transfer is unaffected.
- Address arithmetic is 32-bit. A wrap past 0xFFFF_FFFC continues at 0x0000_0000 with no error.
- `req_len_dw` encodes 1..128 as a plain count; it never reaches 0 or 1024.

## Timing
- Reset values: `req_valid=0`, `req_addr=0`, `req_len_dw=0`, `req_last=0`, `dma_wr_busy=0`, `dma_wr_done=0`, stats=0. State is IDLE.
- Start sampled at cycle T:
  - CALC at T+1.
  - `req_valid` high from T+2.
- After each non-last handshake at cycle H: CALC at H+1, next `req_valid` at H+2. There is one bubble between requests.
- After the last handshake at H: `dma_wr_done` at H+1 and `dma_wr_busy` falls at H+2.
- Zero-length start at T: `dma_wr_done` at T+1 and no request is issued.
- `req_valid` may be high with `req_ready` already high; the handshake completes in that same cycle.
- `pcie_rst` mid-transfer: the next edge returns to IDLE with all outputs at their reset values. The pending request is dropped and no done pulse is produced.

## Configuration
- `DMA_WR_STATS_EN` defined:
  - `stat_req_cnt` increments on every handshake.
  - `stat_drop_cnt` increments on every start ignored while busy and saturates at 0xFFFF.
- `DMA_WR_STATS_EN` undefined: both stat ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `pcie_dma_pkg`:
  - State enum type.
  - `DW_BYTES = 4` constant.
  - Function `dma_chunk(addr, rem, mps)` returning the chunk bytes; it is reused by the read-side generator.
- No sub-module. The datapath (chunk compute plus registers) and the FSM live in one module.

## Test plan
- MPS=128, addr 0x0000_1000, len 256 -> requests (0x1000, 32 DW, last=0) and (0x1080, 32 DW, last=1); done 1 cycle after the second handshake.
- MPS=128, addr 0x0000_01F0, len 64 -> requests (0x01F0, 4 DW) and (0x0200, 12 DW, last=1).
- `req_ready` low for 5 cycles while `req_valid` is high -> `req_addr`/`req_len_dw`/`req_last` are constant throughout; exactly one handshake.
- len 0x3 (rounds to 0) at cycle T -> no `req_valid`, `dma_wr_done` at T+1.
- Second start while busy -> ignored. Original request sequence is unchanged; with `DMA_WR_STATS_EN`, `stat_drop_cnt` = 1 and `stat_req_cnt` = number of handshakes.
- `pcie_rst` asserted during REQ of a 3-request transfer -> outputs at reset values next cycle with no done pulse. A new start then runs normally from IDLE.
